tmp_sinc2_decimator: RTL
========================

Name: tmp_sinc2_decimator

Overview:
Downstream stage of the temperature-sensor sequencing controller. Consumes the comparator decision bitstream that the controller produces each time it resolves a charge-balance cycle (one `cmp_stb` pulse per decision). Runs a 2nd-order CIC (sinc2) decimator over N = 2^DEC_LOG2 decisions and presents an unsigned temperature code on a valid/ready handshake to the readout/register interface.

Parameters:
DEC_LOG2, 4, log2 of decimation ratio N (N = 16 by default); legal range 2..10
SETTLE, 2, number of comb outputs discarded after start/restart (filter warm-up)
W, 2*DEC_LOG2+1, result/accumulator width; derived, not overridable

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
en  in  1  conversion enable; low clears the filter and holds it idle
cmp  in  1  comparator decision bit, sampled only when cmp_stb=1
cmp_stb  in  1  one-cycle strobe: cmp is valid this cycle
result  out  W  decimated code, range 0..N^2
result_valid  out  1  result holds an undelivered code
result_ready  in  1  consumer accepts result when result_valid=1
overrun  out  1  sticky: a code was overwritten before it was accepted
overrun_clr  in  1  synchronous clear of overrun
busy  out  1  en=1 and fewer than SETTLE+1 outputs produced since start

Behaviour:
- Reset (reset_n=0, async): integrators i1, i2, comb delays d1, d2, sample counter, settle counter = 0; result=0, result_valid=0, overrun=0, busy=0.
- All arithmetic is unsigned modulo 2^W; wrap in the integrators is intentional and cancels in the combs. No saturation.
- Integrators: on a clk edge with en=1 and cmp_stb=1: i1 <= i1 + cmp; i2 <= i2 + i1 + cmp (i2 accumulates the post-update i1). With cmp_stb=0, integrators hold.
- Sample counter: 0..N-1, increments on each accepted strobe and wraps at N-1 -> 0. The strobe that wraps it raises a one-cycle internal dec event on the following cycle.
- States: IDLE, RUN, COMB.
  - IDLE: entered on reset or en=0. All filter state is cleared. settle counter=0. busy=0.
  - IDLE -> RUN when en=1. busy=1.
  - RUN -> COMB on dec event.
  - COMB lasts one cycle and registers the comb outputs: c1 = i2 - d1; out = c1 - d2; d1 <= i2; d2 <= c1. It then returns to RUN.
  - Strobes arriving during COMB are integrated normally. The comb uses the i2 snapshot taken at the dec event, not the live value.
- Settle: the first SETTLE comb outputs after leaving IDLE are discarded, counted by the settle counter. busy drops after the first delivered output.
- Latency: result and result_valid update on the edge ending COMB, i.e. 2 clk cycles after the edge that captured the Nth sample.
  - The first delivered code requires (SETTLE+1)*N strobes.
- Handshake:
  - Transfer occurs on an edge where result_valid=1 and result_ready=1.
  - result_valid clears after a transfer unless a new code loads on that same edge. A new code wins: result_valid stays 1 and overrun is not set.
  - If a new code loads while result_valid=1 and result_ready=0, result is overwritten and overrun <= 1.
  - result is stable while result_valid=1 and no new code loads.
- overrun:
  - overrun_clr clears it.
  - If set and clear coincide on the same edge, set wins.
- en deasserted mid-frame: next edge -> IDLE. Partial frame and filter state are cleared. result, result_valid and overrun hold their values, so a pending code can still be drained.
- Constraint: the minimum cmp_stb spacing is 1 cycle, and back-to-back strobes are legal.

Decomposition:
- Shared package tmp_pkg: state enum for IDLE/RUN/COMB, and a function computing W from DEC_LOG2.
  - The sensor controller's state encoding migrates here as well.
- One natural sub-module: tmp_cic_comb. It is the two-stage differentiator plus delay registers, loaded by dec; instantiated once.
- Integrators, counters and the handshake stay in the top.

Test Plan:
- Defaults (N=16, W=9), en=1, cmp=1 on every strobe, strobe every 3 cycles -> first result_valid after 48 strobes; result=256. Every subsequent result=256, one every 16 strobes.
- cmp constant 0 -> result=0. cmp alternating 1,0 -> result=128 steady. 12 ones then 4 zeros per frame, repeated -> result=192 steady.
- result_ready held 0 across two codes -> overrun=1 and result shows the second code. Pulse overrun_clr together with a third code load -> overrun remains 1. Pulse overrun_clr alone -> overrun=0.
- result_ready=1 on the same edge a new code loads -> result_valid stays 1 with the new code, overrun=0.
- Drop en for 1 cycle mid-frame (strobe 7 of 16), then reassert -> the next delivered code appears 48 strobes after reassertion, with value equal to the steady value. A pending code from before the drop is still accepted.
- Assert reset_n=0 asynchronously mid-COMB -> all outputs read 0 immediately. After release, full warm-up is repeated before the first result.

Source files
------------

// File: rtl/tmp_pkg.sv
// Shared types for the temperature-sensor block: controller and decimator state
// encodings plus the CIC width helper.
package tmp_pkg;

    typedef enum logic [1:0] {
        CTRL_IDLE      = 2'd0,
        CTRL_PRECHARGE = 2'd1,
        CTRL_INTEGRATE = 2'd2,
        CTRL_COMPARE   = 2'd3
    } ctrl_state_t;

    typedef enum logic [1:0] {
        DEC_IDLE = 2'd0,
        DEC_RUN  = 2'd1,
        DEC_COMB = 2'd2
    } dec_state_t;

    // A sinc2 over N = 2^dec_log2 one-bit samples peaks at N^2, so 2*log2(N)+1 bits.
    function automatic int cic_width(input int dec_log2);
        return 2 * dec_log2 + 1;
    endfunction

endpackage

// File: rtl/tmp_cic_comb.sv
// Two-stage CIC differentiator. The delay registers advance only when a decimated
// integrator snapshot is loaded. The output is combinational from the snapshot.
module tmp_cic_comb
    import tmp_pkg::*;
#(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] i2_snap,
    output logic [W-1:0] comb_out
);

    logic [W-1:0] d1, d2, c1;

    assign c1       = i2_snap - d1;
    assign comb_out = c1 - d2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            d1 <= '0;
            d2 <= '0;
        end else if (clr) begin
            d1 <= '0;
            d2 <= '0;
        end else if (load) begin
            d1 <= i2_snap;
            d2 <= c1;
        end
    end

endmodule

// File: rtl/tmp_sinc2_decimator.sv
// Sinc2 decimator for the comparator bitstream. It includes the integrators, the
// decimation and warm-up counters, and the valid/ready result register with overrun.
module tmp_sinc2_decimator
    import tmp_pkg::*;
#(
    parameter  int DEC_LOG2 = 4,
    parameter  int SETTLE   = 2,
    localparam int W        = cic_width(DEC_LOG2)
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         en,
    input  logic         cmp,
    input  logic         cmp_stb,
    output logic [W-1:0] result,
    output logic         result_valid,
    input  logic         result_ready,
    output logic         overrun,
    input  logic         overrun_clr,
    output logic         busy
);

    localparam int SW = $clog2(SETTLE + 2);
    localparam logic [SW-1:0] SETTLE_L = SW'(SETTLE);

    dec_state_t          state;
    logic [W-1:0]        i1, i2, i1_nxt, i2_snap, comb_out;
    logic [DEC_LOG2-1:0] smp_cnt;
    logic [SW-1:0]       settle_cnt;
    logic                dec_evt, busy_r;
    logic                stb_acc, comb_go, deliver;

    assign stb_acc = en & cmp_stb;
    assign i1_nxt  = i1 + {{(W-1){1'b0}}, cmp};
    assign comb_go = en && (state == DEC_COMB);
    assign deliver = comb_go && (settle_cnt == SETTLE_L);
    assign busy    = busy_r;

    // Integrators keep running through COMB; only the snapshot feeds the comb.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            i1      <= '0;
            i2      <= '0;
            smp_cnt <= '0;
            dec_evt <= 1'b0;
        end else if (!en) begin
            i1      <= '0;
            i2      <= '0;
            smp_cnt <= '0;
            dec_evt <= 1'b0;
        end else begin
            dec_evt <= stb_acc && (smp_cnt == '1);
            if (stb_acc) begin
                i1      <= i1_nxt;
                i2      <= i2 + i1_nxt;
                smp_cnt <= smp_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= DEC_IDLE;
            settle_cnt <= '0;
            busy_r     <= 1'b0;
            i2_snap    <= '0;
        end else if (!en) begin
            state      <= DEC_IDLE;
            settle_cnt <= '0;
            busy_r     <= 1'b0;
            i2_snap    <= '0;
        end else begin
            case (state)
                DEC_IDLE: begin
                    state  <= DEC_RUN;
                    busy_r <= 1'b1;
                end
                DEC_RUN: begin
                    if (dec_evt) begin
                        state   <= DEC_COMB;
                        i2_snap <= i2;
                    end
                end
                DEC_COMB: begin
                    state <= DEC_RUN;
                    if (deliver) busy_r <= 1'b0;
                    else         settle_cnt <= settle_cnt + 1'b1;
                end
                default: state <= DEC_IDLE;
            endcase
        end
    end

    tmp_cic_comb #(.W(W)) u_comb (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr      (!en),
        .load     (comb_go),
        .i2_snap  (i2_snap),
        .comb_out (comb_out)
    );

    // A fresh code always wins over a simultaneous transfer or overrun clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result       <= '0;
            result_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            if (deliver) begin
                result       <= comb_out;
                result_valid <= 1'b1;
            end else if (result_valid && result_ready) begin
                result_valid <= 1'b0;
            end
            if (deliver && result_valid && !result_ready) overrun <= 1'b1;
            else if (overrun_clr)                           overrun <= 1'b0;
        end
    end

endmodule
